// File: rtl/shift_reg_ctrl.sv
// Command-driven shift register: parallel load plus multi-cycle SHL/SHR/ROL,
// one bit per clock, with a valid/ready command handshake and a done pulse.
module shift_reg_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [$clog2(WIDTH)-1:0] cmd_cnt,
    input  logic [WIDTH-1:0]         d,
    input  logic                     ser_in,
    output logic [WIDTH-1:0]         q,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpShl  = 2'b01;
    localparam logic [1:0] OpShr  = 2'b10;
    localparam logic [1:0] OpRol  = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             accept;

    assign accept = cmd_valid && (state_q == StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            op_q    <= OpLoad;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd_op == OpLoad) begin
                        shreg_d = d;
                        state_d = StDone;
                    end else if (cmd_cnt == '0) begin
                        state_d = StDone;
                    end else begin
                        // Operands are latched here; q only starts moving on the next edge.
                        cnt_d   = cmd_cnt;
                        op_d    = cmd_op;
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                unique case (op_q)
                    OpShl:   shreg_d = {shreg_q[WIDTH-2:0], ser_in};
                    OpShr:   shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
                    OpRol:   shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                    default: shreg_d = shreg_q;
                endcase
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign q         = shreg_q;
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed table-driven bench for shift_reg_ctrl plus hand-written corner sequences
// (reset, mid-shift abort, ignored commands while busy) and a short random pass.
module tb_shift_reg_ctrl;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] SHL = 2'b01;
    localparam logic [1:0] SHR = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [7:0] d;
    logic       ser_in;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .d         (d),
        .ser_in    (ser_in),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] cnt;
        logic [7:0] pre;
        logic [7:0] din;
        logic       sin;
        logic [7:0] exp_q;
        int         exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] v, input logic [1:0] op,
                                        input logic sin);
        case (op)
            SHL:     return {v[6:0], sin};
            SHR:     return {sin, v[7:1]};
            ROL:     return {v[6:0], v[7]};
            default: return v;
        endcase
    endfunction

    // Issues one command, scrambles the operand inputs after acceptance, and checks
    // done latency, busy/ready during the operation, the result, and the return to idle.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] din,
                          input logic sin, input logic [7:0] exp_q, input int exp_lat,
                          input string tag);
        int lat;
        @(negedge clk);
        check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        d         = din;
        ser_in    = sin;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_cnt   = ~cnt;
        d         = ~din;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            check({tag, " busy"}, {30'd0, busy, cmd_ready}, 32'b10);
        end
        if (lat == 0) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " latency"}, 32'(lat), 32'(exp_lat));
            check({tag, " q"}, 32'(q), 32'(exp_q));
            check({tag, " busy@done"}, 32'(busy), 32'd1);
            @(negedge clk);
            check({tag, " idle"}, {29'd0, busy, done, cmd_ready}, 32'b001);
            check({tag, " q hold"}, 32'(q), 32'(exp_q));
        end
    endtask

    logic [1:0] r_op;
    logic [2:0] r_cnt;
    logic [7:0] r_din;
    logic       r_sin;
    logic [7:0] model_q;
    int         lat;

    initial begin
        vecs[0]  = '{LD,  3'd0, 8'h00, 8'hA5, 1'b0, 8'hA5, 1};
        vecs[1]  = '{LD,  3'd0, 8'hA5, 8'h80, 1'b0, 8'h80, 1};
        vecs[2]  = '{SHL, 3'd3, 8'h81, 8'h00, 1'b1, 8'h0F, 4};
        vecs[3]  = '{ROL, 3'd7, 8'h81, 8'h00, 1'b0, 8'hC0, 8};
        vecs[4]  = '{SHR, 3'd0, 8'h81, 8'h00, 1'b1, 8'h81, 1};
        vecs[5]  = '{SHR, 3'd2, 8'h81, 8'hFF, 1'b0, 8'h20, 3};
        vecs[6]  = '{SHR, 3'd1, 8'h81, 8'h00, 1'b1, 8'hC0, 2};
        vecs[7]  = '{SHL, 3'd7, 8'h3C, 8'h00, 1'b0, 8'h00, 8};
        vecs[8]  = '{ROL, 3'd4, 8'h0F, 8'h00, 1'b0, 8'hF0, 5};
        vecs[9]  = '{SHL, 3'd1, 8'hA5, 8'h00, 1'b1, 8'h4B, 2};
        vecs[10] = '{LD,  3'd5, 8'h00, 8'hFF, 1'b0, 8'hFF, 1};
        vecs[11] = '{SHR, 3'd7, 8'h01, 8'h00, 1'b1, 8'hFE, 8};

        // Reset state, then acceptance on the very first edge after release.
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = LD;
        cmd_cnt   = 3'd0;
        d         = 8'h5A;
        ser_in    = 1'b0;
        #2;
        check("reset q", 32'(q), 32'h0);
        check("reset flags", {29'd0, busy, done, cmd_ready}, 32'b001);
        #10 reset_n = 1'b1;
        @(negedge clk);
        check("first edge done", 32'(done), 32'd1);
        check("first edge q", 32'(q), 32'h5A);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("first edge idle", {29'd0, busy, done, cmd_ready}, 32'b001);

        for (int i = 0; i < 12; i++) begin
            do_cmd(LD, 3'd0, vecs[i].pre, 1'b0, vecs[i].pre, 1, $sformatf("v%0d pre", i));
            do_cmd(vecs[i].op, vecs[i].cnt, vecs[i].din, vecs[i].sin, vecs[i].exp_q,
                   vecs[i].exp_lat, $sformatf("v%0d", i));
        end

        // cmd_valid held high with changing operands through SHIFT and DONE.
        do_cmd(LD, 3'd0, 8'h81, 1'b0, 8'h81, 1, "hold pre");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = SHL;
        cmd_cnt   = 3'd3;
        d         = 8'h00;
        ser_in    = 1'b1;
        @(posedge clk);
        #1;
        cmd_op  = LD;
        d       = 8'hFF;
        cmd_cnt = 3'd0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            cmd_op = 2'(i);
            d      = 8'(i * 37);
        end
        cmd_op = LD;
        check("hold latency", 32'(lat), 32'd4);
        check("hold q", 32'(q), 32'h0F);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hold no extra accept", {29'd0, busy, done, cmd_ready}, 32'b001);
        check("hold q after", 32'(q), 32'h0F);

        // Reset between edges during SHIFT aborts without a later done.
        do_cmd(LD, 3'd0, 8'h81, 1'b0, 8'h81, 1, "abort pre");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = SHL;
        cmd_cnt   = 3'd5;
        ser_in    = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort in shift", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort q", 32'(q), 32'h0);
        check("abort flags", {29'd0, busy, done, cmd_ready}, 32'b001);
        @(negedge clk);
        reset_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done || busy) lat = i;
        end
        check("abort no done", 32'(lat), 32'd0);

        // Short random pass against a bench-side model.
        model_q = 8'h5A;
        do_cmd(LD, 3'd0, model_q, 1'b0, model_q, 1, "rnd pre");
        for (int i = 0; i < 16; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_cnt = 3'($urandom_range(0, 7));
            r_din = 8'($urandom);
            r_sin = 1'($urandom_range(0, 1));
            if (r_op == LD) begin
                model_q = r_din;
            end else begin
                for (int k = 0; k < int'(r_cnt); k++) model_q = step(model_q, r_op, r_sin);
            end
            do_cmd(r_op, r_cnt, r_din, r_sin, model_q,
                   (r_op == LD || r_cnt == 3'd0) ? 1 : int'(r_cnt) + 1,
                   $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
